// File: rtl/switch_entry_ctrl.sv
// -----------------------------------------------------------------------------
// switch_entry_ctrl
//   Turns the ten slide switches into a multi-digit entry buffer. SW is
//   synchronised and debounced. A stable one-hot pattern becomes a digit 0..9.
//   One digit is taken per press/release cycle and shifted into the buffer.
//   The buffer is handed downstream through a valid/ready handshake.
//
// Parameters
//   DEBOUNCE_CYC : consecutive stable samples needed to accept a press or a
//                  release (>= 2)
//   NUM_DIGITS   : buffer capacity in digits (1..8)
//
// Ports
//   clk        : system clock, all logic on posedge
//   rst        : synchronous, active-high reset
//   SW         : raw slide switches, bit k set = digit k
//   enter      : 1-cycle pulse, commit the buffer to the output
//   clear      : 1-cycle pulse, discard the buffer and any pending output
//   digits     : BCD buffer, newest digit in [3:0]
//   digit_cnt  : number of digits held
//   out_valid  : digits/digit_cnt committed and stable
//   out_ready  : downstream accepts when out_valid & out_ready
//   busy       : entry FSM not idle
//   err        : present only when SW_MULTIHOT_ERR_EN is defined. Pulses for
//                one cycle on a stable multi-hot pattern or on a dropped digit.
//
// Build option
//   SW_MULTIHOT_ERR_EN : adds the err port and its detection logic.
// -----------------------------------------------------------------------------
module switch_entry_ctrl #(
   parameter int unsigned DEBOUNCE_CYC = 16,
   parameter int unsigned NUM_DIGITS   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [9:0]              SW,
   input  logic                    enter,
   input  logic                    clear,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [3:0]              digit_cnt,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
`ifdef SW_MULTIHOT_ERR_EN
   ,
   output logic                    err
`endif
);

   localparam int unsigned DW = 4 * NUM_DIGITS;
   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

   typedef enum logic [1:0] {StIdle, StArm, StAccept, StRelease} state_e;

   logic [9:0]    r_sw_meta;
   logic [9:0]    r_sw_s;
   state_e        r_state;
   logic [9:0]    r_cand;
   logic [CW-1:0] r_cnt;
   logic          r_mh_block;
   logic [DW-1:0] r_digits;
   logic [3:0]    r_digit_cnt;
   logic          r_out_valid;
   logic          r_busy;

   logic          w_sw_zero;
   logic          w_sw_onehot;
   logic          w_sw_multi;
   logic [CW-1:0] w_cnt_inc;
   logic          w_cnt_done;
   logic [3:0]    w_digit;
   logic          w_accept;
   logic          w_room;
   logic          w_shift;
   logic [DW-1:0] w_digits_nxt;
   logic [3:0]    w_cnt_nxt;
   logic          w_commit;
   logic          w_handshake;

   assign w_sw_zero   = (r_sw_s == 10'd0);
   // A power of two has no bits left after clearing its lowest set bit.
   assign w_sw_onehot = !w_sw_zero && ((r_sw_s & (r_sw_s - 10'd1)) == 10'd0);
   assign w_sw_multi  = !w_sw_zero && !w_sw_onehot;
   assign w_cnt_inc   = r_cnt + CW'(1);
   assign w_cnt_done  = (w_cnt_inc == CW'(DEBOUNCE_CYC));

   always_comb begin
      w_digit = 4'd0;
      for (int k = 0; k < 10; k++) begin
         if (r_cand[k]) begin
            w_digit = 4'(k);
         end
      end
   end

   assign w_accept     = (r_state == StAccept);
   assign w_room       = (r_digit_cnt < 4'(NUM_DIGITS)) && !r_out_valid;
   assign w_shift      = w_accept && w_room;
   assign w_digits_nxt = w_shift ? ((r_digits << 4) | DW'(w_digit)) : r_digits;
   assign w_cnt_nxt    = w_shift ? (r_digit_cnt + 4'd1) : r_digit_cnt;
   // Enter looks at the post-shift count, so a same-cycle accept is included.
   assign w_commit     = enter && !r_out_valid && (w_cnt_nxt != 4'd0);
   assign w_handshake  = r_out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_meta   <= 10'd0;
         r_sw_s      <= 10'd0;
         r_state     <= StIdle;
         r_cand      <= 10'd0;
         r_cnt       <= '0;
         r_mh_block  <= 1'b0;
         r_digits    <= '0;
         r_digit_cnt <= 4'd0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_sw_meta <= SW;
         r_sw_s    <= r_sw_meta;

         // A multi-hot pattern blocks arming until the switches read all-zero.
         if (w_sw_zero) begin
            r_mh_block <= 1'b0;
         end else if (w_sw_multi) begin
            r_mh_block <= 1'b1;
         end

         if (clear) begin
            r_digits    <= '0;
            r_digit_cnt <= 4'd0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= w_sw_zero ? StIdle : StRelease;
            r_busy      <= !w_sw_zero;
         end else begin
            if (w_handshake) begin
               r_digits    <= '0;
               r_digit_cnt <= 4'd0;
               r_out_valid <= 1'b0;
            end else begin
               r_digits    <= w_digits_nxt;
               r_digit_cnt <= w_cnt_nxt;
               if (w_commit) begin
                  r_out_valid <= 1'b1;
               end
            end

            unique case (r_state)
               StIdle: begin
                  if (w_sw_onehot && !r_mh_block) begin
                     r_state <= StArm;
                     r_cand  <= r_sw_s;
                     r_cnt   <= CW'(1);
                     r_busy  <= 1'b1;
                  end else begin
                     r_cnt <= '0;
                  end
               end
               StArm: begin
                  if (r_sw_s == r_cand) begin
                     if (w_cnt_done) begin
                        r_state <= StAccept;
                        r_cnt   <= '0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else if (w_sw_onehot) begin
                     r_cand <= r_sw_s;
                     r_cnt  <= CW'(1);
                  end else begin
                     // Zero or multi-hot: abandon the candidate.
                     r_state <= StIdle;
                     r_cnt   <= '0;
                     r_busy  <= 1'b0;
                  end
               end
               StAccept: begin
                  r_state <= StRelease;
                  r_cnt   <= '0;
               end
               StRelease: begin
                  if (w_sw_zero) begin
                     if (w_cnt_done) begin
                        r_state <= StIdle;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                     end else begin
                        r_cnt <= w_cnt_inc;
                     end
                  end else begin
                     r_cnt <= '0;
                  end
               end
               default: begin
                  r_state <= StIdle;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign digits    = r_digits;
   assign digit_cnt = r_digit_cnt;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

`ifdef SW_MULTIHOT_ERR_EN
   logic [9:0]    r_mh_pat;
   logic [CW-1:0] r_mh_cnt;
   logic          r_mh_flagged;
   logic          r_err;
   logic [CW-1:0] w_mh_cnt_nxt;
   logic          w_mh_stable;

   always_comb begin
      w_mh_cnt_nxt = '0;
      if (w_sw_multi) begin
         if (r_sw_s != r_mh_pat) begin
            w_mh_cnt_nxt = CW'(1);
         end else if (r_mh_cnt != CW'(DEBOUNCE_CYC)) begin
            w_mh_cnt_nxt = r_mh_cnt + CW'(1);
         end else begin
            w_mh_cnt_nxt = r_mh_cnt;
         end
      end
   end

   assign w_mh_stable = (w_mh_cnt_nxt == CW'(DEBOUNCE_CYC));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mh_pat     <= 10'd0;
         r_mh_cnt     <= '0;
         r_mh_flagged <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_err    <= 1'b0;
         r_mh_cnt <= w_mh_cnt_nxt;
         r_mh_pat <= w_sw_multi ? r_sw_s : 10'd0;
         // One report per multi-hot occurrence; re-armed by an all-zero read.
         if (w_sw_zero) begin
            r_mh_flagged <= 1'b0;
         end else if (w_mh_stable && !r_mh_flagged) begin
            r_mh_flagged <= 1'b1;
            r_err        <= 1'b1;
         end
         if (w_accept && !w_room && !clear) begin
            r_err <= 1'b1;
         end
      end
   end

   assign err = r_err;
`endif

endmodule

// File: tb/tb_switch_entry_ctrl.sv
// -----------------------------------------------------------------------------
// tb_switch_entry_ctrl
//   Self-checking bench for switch_entry_ctrl (DEBOUNCE_CYC=4, NUM_DIGITS=4):
//   a directed episode table, hand-written multi-cycle sequences and random
//   press episodes checked against a digit-queue reference model.
// -----------------------------------------------------------------------------
module tb_switch_entry_ctrl;

   localparam int unsigned D   = 4;
   localparam int unsigned N   = 4;
   localparam int unsigned GAP = D + 6;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  SW;
   logic        enter;
   logic        clear;
   logic [15:0] digits;
   logic [3:0]  digit_cnt;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
`ifdef SW_MULTIHOT_ERR_EN
   logic        err;
`endif

   switch_entry_ctrl #(
      .DEBOUNCE_CYC (D),
      .NUM_DIGITS   (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .SW        (SW),
      .enter     (enter),
      .clear     (clear),
      .digits    (digits),
      .digit_cnt (digit_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
`ifdef SW_MULTIHOT_ERR_EN
      ,
      .err       (err)
`endif
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: queue of accepted digits (oldest first) and a valid flag.
   int q[$];
   bit m_valid;

   typedef struct {
      logic [9:0]  sw;
      int          hold;
      int          op;        // 0 none, 1 enter, 2 clear, 3 out_ready pulse
      int          exp_cnt;
      logic [15:0] exp_dig;
      bit          exp_valid;
   } vec_t;

   vec_t tbl [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      SW        = 10'd0;
      enter     = 1'b0;
      clear     = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      q.delete();
      m_valid = 1'b0;
   endtask

   // Press pattern for hold cycles, then release for GAP cycles.
   task automatic episode(input logic [9:0] sw, input int hold);
      if (hold > 0) begin
         SW = sw;
         repeat (hold) step();
      end
      SW = 10'd0;
      repeat (GAP) step();
   endtask

   task automatic do_op(input int op);
      case (op)
         1: begin enter = 1'b1; step(); enter = 1'b0; end
         2: begin clear = 1'b1; step(); clear = 1'b0; end
         3: begin out_ready = 1'b1; step(); out_ready = 1'b0; end
         default: ;
      endcase
      step();
   endtask

   task automatic check_state(input string tag, input int cnt, input logic [15:0] dig,
                              input bit valid);
      check({tag, " digit_cnt"}, 32'(digit_cnt), 32'(cnt));
      check({tag, " digits"}, 32'(digits), 32'(dig));
      check({tag, " out_valid"}, 32'(out_valid), 32'(valid));
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   function automatic logic [15:0] m_digits();
      logic [15:0] v = 16'd0;
      foreach (q[i]) v = (v << 4) | 16'(q[i]);
      return v;
   endfunction

   task automatic m_op(input int op);
      case (op)
         1: if (q.size() > 0 && !m_valid) m_valid = 1'b1;
         2: begin q.delete(); m_valid = 1'b0; end
         3: if (m_valid) begin q.delete(); m_valid = 1'b0; end
         default: ;
      endcase
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      // sw, hold, op, exp_cnt, exp_dig, exp_valid
      tbl[0]  = '{10'h008, 10, 0, 1, 16'h0003, 1'b0};
      tbl[1]  = '{10'h008,  3, 0, 1, 16'h0003, 1'b0};  // one short of debounce
      tbl[2]  = '{10'h080,  4, 0, 2, 16'h0037, 1'b0};  // exactly debounce
      tbl[3]  = '{10'h011, 10, 0, 2, 16'h0037, 1'b0};  // multi-hot
      tbl[4]  = '{10'h200,  6, 0, 3, 16'h0379, 1'b0};
      tbl[5]  = '{10'h000,  0, 1, 3, 16'h0379, 1'b1};
      tbl[6]  = '{10'h002,  8, 0, 3, 16'h0379, 1'b1};  // dropped while valid
      tbl[7]  = '{10'h000,  0, 3, 0, 16'h0000, 1'b0};
      tbl[8]  = '{10'h001,  5, 0, 1, 16'h0000, 1'b0};  // digit 0
      tbl[9]  = '{10'h000,  0, 1, 1, 16'h0000, 1'b1};
      tbl[10] = '{10'h000,  0, 2, 0, 16'h0000, 1'b0};
      tbl[11] = '{10'h000,  0, 3, 0, 16'h0000, 1'b0};  // ready without valid
      tbl[12] = '{10'h000,  0, 1, 0, 16'h0000, 1'b0};  // enter on empty buffer
      tbl[13] = '{10'h100,  7, 0, 1, 16'h0008, 1'b0};
      tbl[14] = '{10'h004,  4, 0, 2, 16'h0082, 1'b0};
      tbl[15] = '{10'h010,  9, 0, 3, 16'h0824, 1'b0};
      tbl[16] = '{10'h040,  5, 0, 4, 16'h8246, 1'b0};
      tbl[17] = '{10'h002,  6, 0, 4, 16'h8246, 1'b0};  // full, dropped
      tbl[18] = '{10'h000,  0, 1, 4, 16'h8246, 1'b1};
      tbl[19] = '{10'h000,  0, 3, 0, 16'h0000, 1'b0};

      do_reset();
      check_state("reset", 0, 16'h0000, 1'b0);

      // Latency: one-hot SW to updated digits takes 2 + D + 1 cycles.
      SW = 10'h008;
      step(); step();
      check("lat busy before arm", 32'(busy), 32'd0);
      step();
      check("lat busy in arm", 32'(busy), 32'd1);
      step(); step(); step();
      check("lat cnt at cycle 6", 32'(digit_cnt), 32'd0);
      step();
      check("lat cnt at cycle 7", 32'(digit_cnt), 32'd1);
      check("lat digits at cycle 7", 32'(digits), 32'h3);
      episode(10'h000, 0);
      check_state("lat release", 1, 16'h0003, 1'b0);

      // Enter in the same cycle as the accept commits the new digit too.
      SW = 10'h010;
      repeat (6) step();
      enter = 1'b1;
      step();
      enter = 1'b0;
      check("enter+accept valid", 32'(out_valid), 32'd1);
      check("enter+accept digits", 32'(digits), 32'h34);
      check("enter+accept cnt", 32'(digit_cnt), 32'd2);
      episode(10'h000, 0);
      do_op(3);
      check_state("enter+accept drained", 0, 16'h0000, 1'b0);

      // Bounce: toggling faster than the debounce window accepts nothing.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         SW = (i % 2 == 0) ? 10'h008 : 10'h000;
         step();
         step();
      end
      episode(10'h000, 0);
      check_state("bounce", 0, 16'h0000, 1'b0);

      // Entries 1..5, fifth dropped; valid held while out_ready low.
      do_reset();
      for (int d = 1; d <= 5; d++) episode(10'(1) << d, 8);
      do_op(1);
      for (int i = 0; i < 5; i++) begin
         check("hold valid", 32'(out_valid), 32'd1);
         check("hold digits", 32'(digits), 32'h1234);
         check("hold cnt", 32'(digit_cnt), 32'd4);
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_state("after handshake", 0, 16'h0000, 1'b0);

      // Enter and clear together: clear wins.
      do_reset();
      episode(10'h080, 6);
      episode(10'h200, 6);
      enter = 1'b1;
      clear = 1'b1;
      step();
      enter = 1'b0;
      clear = 1'b0;
      check_state("enter+clear", 0, 16'h0000, 1'b0);
      step();
      check("enter+clear later valid", 32'(out_valid), 32'd0);

      // Reset during arm with the switch held: re-arms and accepts after 2+D+1.
      do_reset();
      SW = 10'h040;
      repeat (4) step();
      rst = 1'b1;
      step();
      check("rst mid-arm busy", 32'(busy), 32'd0);
      check("rst mid-arm cnt", 32'(digit_cnt), 32'd0);
      rst = 1'b0;
      repeat (6) step();
      check("rearm cnt at cycle 6", 32'(digit_cnt), 32'd0);
      step();
      check("rearm cnt at cycle 7", 32'(digit_cnt), 32'd1);
      check("rearm digits", 32'(digits), 32'h6);
      episode(10'h000, 0);

      // Directed episode table.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         episode(tbl[i].sw, tbl[i].hold);
         do_op(tbl[i].op);
         check_state($sformatf("tbl[%0d]", i), tbl[i].exp_cnt, tbl[i].exp_dig,
                     tbl[i].exp_valid);
      end

      // Random press episodes against the reference model.
      do_reset();
      for (int it = 0; it < 150; it++) begin
         int kind;
         int d;
         int h;
         int b2;
         int op;
         kind = int'($urandom_range(0, 3));
         d    = int'($urandom_range(0, 9));
         case (kind)
            0: begin
               h  = int'($urandom_range(1, D + 5));
               SW = 10'(1) << d;
               repeat (h) step();
               // Accepted only after D stable samples.
               if (h >= D && q.size() < N && !m_valid) q.push_back(d);
            end
            1: begin
               b2 = (d + int'($urandom_range(1, 9))) % 10;
               SW = (10'(1) << d) | (10'(1) << b2);
               repeat (int'($urandom_range(1, D + 5))) step();
            end
            2: begin
               // Multi-hot then one-hot without passing through zero: no accept.
               b2 = (d + int'($urandom_range(1, 9))) % 10;
               SW = (10'(1) << d) | (10'(1) << b2);
               repeat (int'($urandom_range(1, 4))) step();
               SW = 10'(1) << b2;
               repeat (D + 3) step();
            end
            default: begin
               for (int s = 0; s < 3; s++) begin
                  SW = 10'(1) << d;
                  repeat (int'($urandom_range(1, D - 1))) step();
                  SW = 10'd0;
                  repeat (int'($urandom_range(1, D - 1))) step();
               end
            end
         endcase
         episode(10'h000, 0);
         op = int'($urandom_range(0, 5));
         if (op > 3) op = 1;
         do_op(op);
         m_op(op);
         check_state($sformatf("rand[%0d]", it), q.size(), m_digits(), m_valid);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
